parity_stream_reader: RTL and testbench

//  Read-side counterpart of the parity-encoding data memory.

---
 rtl/pkg_mem_codec.sv | 20 ++
 rtl/parity_stream_reader.sv | 126 ++++++++++++
 tb/tb_parity_stream_reader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pkg_mem_codec.sv
// Shared definitions for the parity-encoded data memory codec (writer and reader sides).
// Message bytes are stored as {^orig, orig[6:0]}, so a clean 7-bit char has even overall parity.
package pkg_mem_codec;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam logic [6:0] DELIM_CHAR    = 7'h00;
    localparam logic [7:0] MSG_REGION_LO = 8'd64;
    localparam logic [7:0] MSG_REGION_HI = 8'd127;

    function automatic logic parity_ok(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/parity_stream_reader.sv
// Scans a block of parity-encoded bytes, strips bit 7 and streams 7-bit chars on valid/ready,
// flagging and counting bytes whose overall parity is odd.
module parity_stream_reader
    import pkg_mem_codec::*;
#(
    parameter bit STOP_ON_DELIM = 1'b1,
    parameter int MAX_LEN       = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] BaseAddr,
    input  logic [6:0] Length,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemData,
    output logic       OutValid,
    input  logic       OutReady,
    output logic [6:0] OutChar,
    output logic       OutParityErr,
    output logic       Busy,
    output logic       Done,
    output logic [6:0] ErrCount
);

    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

    rd_state_t  r_state;
    rd_state_t  w_state_next;
    logic [7:0] r_base;
    logic [6:0] r_len;
    logic [6:0] r_index;
    logic       r_addr_ok;
    logic       r_out_valid;
    logic [6:0] r_out_char;
    logic       r_out_perr;
    logic [6:0] r_err_count;

    logic       w_mem_perr;
    logic       w_delim;
    logic       w_can_load;
    logic       w_load;
    logic [6:0] w_len_clamped;

    always_comb begin
        w_mem_perr    = ~parity_ok(MemData);
        w_delim       = STOP_ON_DELIM && !w_mem_perr && (MemData[6:0] == DELIM_CHAR);
        // The first RUN cycle only presents the new base address; sampling starts one cycle later.
        w_can_load    = (r_state == RUN) && r_addr_ok && (!r_out_valid || OutReady) && (r_index < r_len);
        w_load        = w_can_load && !w_delim;
        w_len_clamped = (Length > LEN_MAX) ? LEN_MAX : Length;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_can_load && w_delim) begin
                    w_state_next = DRAIN;
                end else if (w_load && ((r_index + 7'd1) == r_len)) begin
                    w_state_next = DRAIN;
                end else if (r_addr_ok && (r_index >= r_len)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_out_valid || OutReady) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_base      <= 8'd0;
            r_len       <= 7'd0;
            r_index     <= 7'd0;
            r_addr_ok   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= 7'd0;
            r_out_perr  <= 1'b0;
            r_err_count <= 7'd0;
        end else begin
            r_state   <= w_state_next;
            r_addr_ok <= (r_state == RUN);
            if ((r_state == IDLE) && Start) begin
                r_base      <= BaseAddr;
                r_len       <= w_len_clamped;
                r_index     <= 7'd0;
                r_err_count <= 7'd0;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_char  <= MemData[6:0];
                r_out_perr  <= w_mem_perr;
                r_index     <= r_index + 7'd1;
                if (w_mem_perr && (r_err_count != 7'd127)) begin
                    r_err_count <= r_err_count + 7'd1;
                end
            end else if (OutReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign MemAddr      = r_base + {1'b0, r_index};
    assign OutValid     = r_out_valid;
    assign OutChar      = r_out_char;
    assign OutParityErr = r_out_perr;
    assign ErrCount     = r_err_count;
    assign Busy         = (r_state == RUN) || (r_state == DRAIN);
    assign Done         = (r_state == DONE);

endmodule

// File: tb/tb_parity_stream_reader.sv
// Directed and randomized scans against a queue-based reference of the expected character stream.
module tb_parity_stream_reader;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] BaseAddr;
    logic [6:0] Length;
    logic [7:0] MemAddr;
    logic [7:0] MemData;
    logic       OutValid;
    logic       OutReady;
    logic [6:0] OutChar;
    logic       OutParityErr;
    logic       Busy;
    logic       Done;
    logic [6:0] ErrCount;

    logic [7:0] mem [256];
    assign MemData = mem[MemAddr];

    parity_stream_reader #(.STOP_ON_DELIM(1'b1), .MAX_LEN(64)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .Length(Length),
        .MemAddr(MemAddr), .MemData(MemData), .OutValid(OutValid), .OutReady(OutReady),
        .OutChar(OutChar), .OutParityErr(OutParityErr), .Busy(Busy), .Done(Done),
        .ErrCount(ErrCount)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       perr;
        logic [6:0] ch;
    } beat_t;

    beat_t exp_q[$];
    int    exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stream: walk the block in address order, stop at a clean delimiter.
    task automatic build_expected(input logic [7:0] base, input int len);
        int n;
        n = (len > 64) ? 64 : len;
        exp_q.delete();
        exp_err = 0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            bit         bad;
            b   = mem[(int'(base) + i) % 256];
            bad = ($countones(b) % 2) != 0;
            if (!bad && (b[6:0] == 7'h00)) break;
            exp_q.push_back({bad, b[6:0]});
            if (bad && exp_err < 127) exp_err++;
        end
    endtask

    task automatic put_byte(input int addr, input logic [6:0] ch, input bit bad);
        mem[addr % 256] = {(^ch) ^ bad, ch};
    endtask

    task automatic run_scan(input logic [7:0] base, input logic [6:0] len, input int mode,
                            input bit chk_lat, input bit glitch,
                            output int last_acc, output int done_at);
        int         done_cnt;
        bit         stalled;
        logic [6:0] held_char;
        logic       held_perr;
        beat_t      e;
        build_expected(base, int'(len));
        done_cnt = 0;
        stalled  = 0;
        last_acc = -1;
        done_at  = -1;
        held_char = '0;
        held_perr = 1'b0;
        @(negedge Clk);
        BaseAddr = base;
        Length   = len;
        Start    = 1'b1;
        @(negedge Clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            Start = 1'b0;
            case (mode)
                0:       OutReady = 1'b1;
                1:       OutReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: OutReady = 1'($urandom_range(0, 1));
            endcase
            if (glitch && cyc == 4) begin
                Start    = 1'b1;
                BaseAddr = base + 8'd3;
                Length   = 7'd1;
            end
            if (chk_lat) begin
                if (cyc == 0) chk("first_addr", 32'(MemAddr), 32'(base));
                if (cyc == 1) chk("latency_n1_valid", 32'(OutValid), 32'd0);
                if (cyc == 2) chk("latency_n2_valid", 32'(OutValid), 32'd1);
            end
            if (stalled) begin
                chk("stall_valid", 32'(OutValid), 32'd1);
                chk("stall_char", 32'(OutChar), 32'(held_char));
                chk("stall_perr", 32'(OutParityErr), 32'(held_perr));
            end
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_char", 32'(OutChar), 32'(e.ch));
                    chk("beat_perr", 32'(OutParityErr), 32'(e.perr));
                end
                last_acc = cyc;
            end
            stalled   = OutValid && !OutReady;
            held_char = OutChar;
            held_perr = OutParityErr;
            if (Done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_at = cyc;
                    chk("done_errcount", 32'(ErrCount), 32'(exp_err));
                end
            end
            if (done_cnt > 0 && cyc >= done_at + 2) break;
            @(negedge Clk);
        end
        Start = 1'b0;
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("beats_missing", 32'(exp_q.size()), 32'd0);
        chk("idle_busy", 32'(Busy), 32'd0);
        chk("idle_valid", 32'(OutValid), 32'd0);
        chk("idle_errcount", 32'(ErrCount), 32'(exp_err));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int la, da, accepts, done_seen;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        Reset = 1'b1; Start = 1'b0; BaseAddr = 8'd0; Length = 7'd0; OutReady = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_valid", 32'(OutValid), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_errcount", 32'(ErrCount), 32'd0);
        chk("rst_memaddr", 32'(MemAddr), 32'd0);
        chk("rst_char", 32'(OutChar), 32'd0);
        chk("rst_perr", 32'(OutParityErr), 32'd0);
        Reset = 1'b0;

        // Basic block with ready held high: latency, back-to-back beats, Done one cycle after last beat.
        mem[64] = 8'h41; mem[65] = 8'hC3; mem[66] = 8'hC4;
        run_scan(8'd64, 7'd3, 0, 1'b1, 1'b0, la, da);
        chk("done_after_last_beat", 32'(da - la), 32'd1);

        // One bad byte then a clean one.
        mem[64] = 8'h43; mem[65] = 8'h41;
        run_scan(8'd64, 7'd2, 0, 1'b0, 1'b0, la, da);

        // Delimiter stops the scan without being emitted.
        mem[70] = 8'h41; mem[71] = 8'h00; mem[72] = 8'h42;
        run_scan(8'd70, 7'd3, 0, 1'b0, 1'b0, la, da);

        // Bad-parity delimiter is data, scan continues.
        mem[70] = 8'h41; mem[71] = 8'h80; mem[72] = 8'h42;
        run_scan(8'd70, 7'd3, 0, 1'b0, 1'b0, la, da);

        // Backpressure 1,0,0,1 over the first block.
        mem[64] = 8'h41; mem[65] = 8'hC3; mem[66] = 8'hC4;
        run_scan(8'd64, 7'd3, 1, 1'b0, 1'b0, la, da);

        // Address wrap and empty scan.
        mem[254] = 8'h41; mem[255] = 8'h42; mem[0] = 8'h44; mem[1] = 8'hC5;
        run_scan(8'd254, 7'd4, 0, 1'b1, 1'b0, la, da);
        run_scan(8'd10, 7'd0, 0, 1'b0, 1'b0, la, da);

        // Over-long length clamps to 64 bytes; Start mid-scan is ignored.
        for (int a = 128; a < 256; a++) put_byte(a, 7'(1 + (a % 100)), (a % 7) == 0);
        run_scan(8'd128, 7'd100, 2, 1'b0, 1'b1, la, da);

        // Randomized blocks with random backpressure.
        for (int t = 0; t < 10; t++) begin
            logic [7:0] b;
            logic [6:0] l;
            b = 8'($urandom_range(0, 255));
            l = 7'($urandom_range(0, 80));
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 30) == 0) put_byte(int'(b) + i, 7'h00, 1'b0);
                else put_byte(int'(b) + i, 7'($urandom_range(1, 127)), $urandom_range(0, 5) == 0);
            end
            run_scan(b, l, 2, 1'b0, 1'b0, la, da);
        end

        // Reset after the second accepted beat aborts without Done.
        for (int i = 0; i < 8; i++) put_byte(32 + i, 7'h50 + 7'(i), i == 0);
        @(negedge Clk);
        BaseAddr = 8'd32; Length = 7'd8; Start = 1'b1; OutReady = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        accepts = 0;
        for (int cyc = 0; cyc < 50 && accepts < 2; cyc++) begin
            if (OutValid && OutReady) accepts++;
            if (accepts < 2) @(negedge Clk);
        end
        chk("reset_reached_two_beats", 32'(accepts), 32'd2);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_valid", 32'(OutValid), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_errcount", 32'(ErrCount), 32'd0);
        chk("abort_memaddr", 32'(MemAddr), 32'd0);
        done_seen = 0;
        if (Done) done_seen++;
        Reset = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            if (Done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);

        // Recovery after abort.
        run_scan(8'd32, 7'd8, 2, 1'b1, 1'b0, la, da);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
